// File: rtl/fetch_ctrl.sv
// fetch_ctrl -- instruction-fetch sequencer between the PC register, the
// instruction memory and the IF/ID order register.
//
// Optional feature: define FETCH_TIMEOUT_EN to build the fetch watchdog.
// Without it fetch_timeout is tied low and no counter exists.
//
// Ports
//   clk, rst                         clock, asynchronous active-high reset
//   pc_cur, plus_four                current PC and PC+4 from the datapath
//   redirect_valid, redirect_target  taken branch/jump from EX
//   stall                            hazard unit holds IF/ID
//   imem_req, imem_addr              memory request (combinational)
//   imem_ack, imem_rdata             memory acknowledge and instruction
//   pc_in_data, pc_we                next PC and write strobe (combinational)
//   order_data, order_pc, order_valid  registered instruction to ID
//   fetch_timeout                    sticky watchdog flag (registered)
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_cur,
  input  logic [31:0] plus_four,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_in_data,
  output logic        pc_we,
  output logic [31:0] order_data,
  output logic [31:0] order_pc,
  output logic        order_valid,
  output logic        fetch_timeout
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state;
  logic            pend_valid;
  logic [XLEN-1:0] pend_target;

  // The PC register itself resets to RESET_PC; this block never writes it
  // during IDLE, so the parameter only documents the expected reset PC.
  logic unused_params;
  assign unused_params = ^{RESET_PC, 32'(TIMEOUT_CYCLES)};

  // Memory request and PC update strobes
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = pc_cur;
    pc_we      = 1'b0;
    pc_in_data = plus_four;
    if (!rst) begin
      unique case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pc_we = 1'b1;
            // A live redirect beats one latched while the request was out
            if (redirect_valid)  pc_in_data = redirect_target;
            else if (pend_valid) pc_in_data = pend_target;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc_we      = 1'b1;
            pc_in_data = redirect_target;
          end
        end
        default: ;
      endcase
    end
  end

  // State, pending redirect and order register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      order_valid <= 1'b0;
      order_data  <= NOP_INSN;
      order_pc    <= '0;
    end else begin
      unique case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            if (redirect_valid || pend_valid) begin
              // Wrong-path instruction: drop it, refetch from the target
              order_valid <= 1'b0;
              pend_valid  <= 1'b0;
            end else begin
              order_valid <= 1'b1;
              order_data  <= imem_rdata;
              order_pc    <= pc_cur;
              state       <= stall ? HOLD : FETCH;
            end
          end else if (redirect_valid) begin
            // Request stays outstanding; remember where to go once it lands
            pend_valid  <= 1'b1;
            pend_target <= redirect_target;
            order_valid <= 1'b0;
          end else if (!stall) begin
            order_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            order_valid <= 1'b0;
            state       <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Watchdog: counts unacknowledged fetch cycles, flag is sticky until rst
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt        <= '0;
      fetch_timeout <= 1'b0;
    end else if (state == FETCH) begin
      if (imem_ack) begin
        wd_cnt <= '0;
      end else begin
        if (wd_cnt != CNT_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + CNT_W'(1);
        if (wd_cnt >= CNT_W'(TIMEOUT_CYCLES - 1)) fetch_timeout <= 1'b1;
      end
    end
  end
`else
  assign fetch_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_fetch_ctrl;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO    = 4;
  localparam bit          TO_EN = 1'b1;
`else
  localparam int unsigned TO    = 255;
  localparam bit          TO_EN = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] plus_four;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] pc_in_data;
  logic        pc_we;
  logic [31:0] order_data;
  logic [31:0] order_pc;
  logic        order_valid;
  logic        fetch_timeout;

  assign plus_four = pc + 32'd4;

  always #5 clk = ~clk;

  fetch_ctrl #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pc_cur(pc), .plus_four(plus_four),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_in_data(pc_in_data),
    .pc_we(pc_we), .order_data(order_data), .order_pc(order_pc),
    .order_valid(order_valid), .fetch_timeout(fetch_timeout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: "running" becomes true one edge after reset release,
  // "holding" means the front end is parked by a stall after a delivery.
  logic        m_run, m_hold, m_pend, m_ov, m_to;
  logic [31:0] m_pend_tgt, m_od, m_opc;
  int          m_wait;
  logic        e_req, e_we;
  logic [31:0] e_pcin;

  function automatic void model_reset();
    m_run = 0; m_hold = 0; m_pend = 0; m_ov = 0; m_to = 0;
    m_pend_tgt = 0; m_od = NOP; m_opc = 0; m_wait = 0;
  endfunction

  function automatic void model_comb();
    e_req  = m_run && !m_hold;
    e_we   = 1'b0;
    e_pcin = pc + 32'd4;
    if (e_req && imem_ack) begin
      e_we = 1'b1;
      if (redirect_valid) e_pcin = redirect_target;
      else if (m_pend)    e_pcin = m_pend_tgt;
    end else if (m_run && m_hold && redirect_valid) begin
      e_we   = 1'b1;
      e_pcin = redirect_target;
    end
  endfunction

  function automatic void model_clock();
    if (!m_run) begin
      m_run = 1;
    end else if (!m_hold) begin
      if (imem_ack) begin
        m_wait = 0;
        if (redirect_valid || m_pend) begin
          m_ov = 0; m_pend = 0;
        end else begin
          m_ov = 1; m_od = imem_rdata; m_opc = pc; m_hold = stall;
        end
      end else begin
        m_wait++;
        if (TO_EN && m_wait >= int'(TO)) m_to = 1;
        if (redirect_valid) begin
          m_pend = 1; m_pend_tgt = redirect_target; m_ov = 0;
        end else if (!stall) begin
          m_ov = 0;
        end
      end
    end else begin
      if (redirect_valid) begin m_ov = 0; m_hold = 0; end
      else m_hold = stall;
    end
  endfunction

  // Advance one clock; the bench plays the PC register
  task automatic tick();
    logic        we;
    logic [31:0] d;
    we = pc_we;
    d  = pc_in_data;
    @(posedge clk);
    #1;
    if (we && !rst) pc = d;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst = 1; imem_ack = 0; imem_rdata = 0; redirect_valid = 0;
    redirect_target = 0; stall = 0; pc = pc0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; imem_ack = 1; pc = 32'h1234_5678;
    @(posedge clk); #1;
    n_tests++; if (order_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ov: got %0b want 0", order_valid); end
    n_tests++; if (order_data !== NOP) begin n_fail++; $display("FAIL rst_od: got %h want %h", order_data, NOP); end
    n_tests++; if (order_pc !== 32'h0) begin n_fail++; $display("FAIL rst_opc: got %h want 0", order_pc); end
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0b want 0", imem_req); end
    n_tests++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL rst_we: got %0b want 0", pc_we); end
    n_tests++; if (fetch_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_to: got %0b want 0", fetch_timeout); end
    n_tests++; if (imem_addr !== 32'h1234_5678) begin n_fail++; $display("FAIL rst_addr: got %h want 12345678", imem_addr); end
    rst = 0; #1;
    n_tests++; if (imem_req !== 1'b0 || pc_we !== 1'b0) begin n_fail++; $display("FAIL idle_req_we: got %0b/%0b want 0/0", imem_req, pc_we); end
  endtask

  task automatic test_sequential();
    do_reset(32'h0);
    imem_ack = 1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata = 32'hA000_0000 | 32'(i);
      #1;
      if (i == 0) begin
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_idle_req: got %0b want 0", imem_req); end
      end else begin
        n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'((i - 1) * 4)) begin
          n_fail++; $display("FAIL seq_addr%0d: got req %0b addr %h want 1 %h", i, imem_req, imem_addr, 32'((i - 1) * 4)); end
      end
      tick();
      if (i == 0) begin
        n_tests++; if (order_valid !== 1'b0) begin n_fail++; $display("FAIL seq_ov0: got %0b want 0", order_valid); end
      end else begin
        n_tests++; if (order_valid !== 1'b1 || order_pc !== 32'((i - 1) * 4) || order_data !== (32'hA000_0000 | 32'(i))) begin
          n_fail++; $display("FAIL seq_order%0d: got %0b %h %h want 1 %h %h", i, order_valid, order_pc, order_data, 32'((i - 1) * 4), 32'hA000_0000 | 32'(i)); end
      end
    end
  endtask

  task automatic test_ack_delay();
    do_reset(32'h10);
    #1; tick();
    for (int i = 0; i < 4; i++) begin
      imem_ack = (i == 3); imem_rdata = 32'hDEAD_0010;
      #1;
      n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        n_fail++; $display("FAIL dly_req%0d: got %0b %h want 1 00000010", i, imem_req, imem_addr); end
      tick();
      if (i < 3) begin
        n_tests++; if (order_valid !== 1'b0) begin n_fail++; $display("FAIL dly_ov%0d: got %0b want 0", i, order_valid); end
      end else begin
        n_tests++; if (order_valid !== 1'b1 || order_data !== 32'hDEAD_0010 || order_pc !== 32'h10) begin
          n_fail++; $display("FAIL dly_order: got %0b %h %h want 1 dead0010 00000010", order_valid, order_data, order_pc); end
      end
    end
    imem_ack = 0;
  endtask

  task automatic test_redirect_pending();
    do_reset(32'h20);
    #1; tick();
    redirect_valid = 1; redirect_target = 32'h100; #1;
    n_tests++; if (pc_we !== 1'b0) begin n_fail++; $display("FAIL pend_we: got %0b want 0", pc_we); end
    tick();
    redirect_valid = 0; imem_ack = 1; imem_rdata = 32'h0BAD_0BAD; #1;
    n_tests++; if (pc_we !== 1'b1 || pc_in_data !== 32'h100 || imem_addr !== 32'h20) begin
      n_fail++; $display("FAIL pend_ack: got %0b %h %h want 1 00000100 00000020", pc_we, pc_in_data, imem_addr); end
    tick();
    n_tests++; if (order_valid !== 1'b0 || order_data !== NOP) begin
      n_fail++; $display("FAIL pend_drop: got %0b %h want 0 %h", order_valid, order_data, NOP); end
    imem_ack = 0; #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      n_fail++; $display("FAIL pend_next: got %0b %h want 1 00000100", imem_req, imem_addr); end
  endtask

  task automatic test_stall_hold();
    do_reset(32'h30);
    #1; tick();
    imem_ack = 1; imem_rdata = 32'h3030_0013; stall = 1; #1;
    tick();
    n_tests++; if (order_valid !== 1'b1 || order_pc !== 32'h30 || order_data !== 32'h3030_0013) begin
      n_fail++; $display("FAIL hold_first: got %0b %h %h want 1 00000030 30300013", order_valid, order_pc, order_data); end
    imem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (imem_req !== 1'b0 || pc_we !== 1'b0) begin
        n_fail++; $display("FAIL hold_req%0d: got %0b %0b want 0 0", i, imem_req, pc_we); end
      tick();
      n_tests++; if (order_valid !== 1'b1 || order_pc !== 32'h30 || order_data !== 32'h3030_0013) begin
        n_fail++; $display("FAIL hold_keep%0d: got %0b %h %h want 1 00000030 30300013", i, order_valid, order_pc, order_data); end
    end
    redirect_valid = 1; redirect_target = 32'h200; #1;
    n_tests++; if (pc_we !== 1'b1 || pc_in_data !== 32'h200) begin
      n_fail++; $display("FAIL hold_redir_we: got %0b %h want 1 00000200", pc_we, pc_in_data); end
    tick();
    n_tests++; if (order_valid !== 1'b0) begin n_fail++; $display("FAIL hold_redir_ov: got %0b want 0", order_valid); end
    redirect_valid = 0; stall = 0; imem_rdata = 32'h2000_0013; #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_fail++; $display("FAIL hold_resume: got %0b %h want 1 00000200", imem_req, imem_addr); end
    tick();
    n_tests++; if (order_valid !== 1'b1 || order_pc !== 32'h200) begin
      n_fail++; $display("FAIL hold_resume_order: got %0b %h want 1 00000200", order_valid, order_pc); end
    imem_ack = 0;
  endtask

  task automatic test_timeout();
    do_reset(32'h50);
    #1; tick();
    imem_ack = 0;
    for (int i = 1; i <= 6; i++) begin
      #1; tick();
      n_tests++; if (fetch_timeout !== (TO_EN && i >= int'(TO))) begin
        n_fail++; $display("FAIL to_wait%0d: got %0b want %0b", i, fetch_timeout, TO_EN && i >= int'(TO)); end
    end
    imem_ack = 1; #1; tick();
    n_tests++; if (fetch_timeout !== TO_EN) begin n_fail++; $display("FAIL to_sticky: got %0b want %0b", fetch_timeout, TO_EN); end
    rst = 1; #1;
    n_tests++; if (fetch_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %0b want 0", fetch_timeout); end
    imem_ack = 0;
  endtask

  task automatic test_reset_midwait();
    do_reset(32'h40);
    #1; tick();
    imem_ack = 0; #1; tick();
    #2; rst = 1; imem_ack = 1; imem_rdata = 32'h4444_4444; #1;
    n_tests++; if (imem_req !== 1'b0 || pc_we !== 1'b0 || order_valid !== 1'b0 || order_data !== NOP || order_pc !== 32'h0) begin
      n_fail++; $display("FAIL mid_rst: got %0b %0b %0b %h %h want 0 0 0 %h 0", imem_req, pc_we, order_valid, order_data, order_pc, NOP); end
    @(posedge clk); #1;
    rst = 0; #1;
    n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got %0b want 0", imem_req); end
    tick(); #1;
    n_tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || order_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_restart: got %0b %h %0b want 1 00000040 0", imem_req, imem_addr, order_valid); end
    tick();
    n_tests++; if (order_valid !== 1'b1 || order_pc !== 32'h40 || order_data !== 32'h4444_4444) begin
      n_fail++; $display("FAIL mid_order: got %0b %h %h want 1 00000040 44444444", order_valid, order_pc, order_data); end
    imem_ack = 0;
  endtask

  task automatic test_random();
    do_reset({$urandom_range(0, 1023), 2'b00} & 32'hFFF);
    for (int c = 0; c < 400; c++) begin
      imem_ack        = ($urandom_range(0, 1) == 0);
      imem_rdata      = $urandom;
      redirect_valid  = ($urandom_range(0, 4) == 0);
      redirect_target = {$urandom_range(0, 16383), 2'b00} & 32'hFFFF;
      stall           = ($urandom_range(0, 2) == 0);
      #1;
      model_comb();
      n_tests++; if (imem_req !== e_req || imem_addr !== pc) begin
        n_fail++; $display("FAIL rnd_req c%0d: got %0b %h want %0b %h", c, imem_req, imem_addr, e_req, pc); end
      n_tests++; if (pc_we !== e_we || pc_in_data !== e_pcin) begin
        n_fail++; $display("FAIL rnd_pc c%0d: got %0b %h want %0b %h", c, pc_we, pc_in_data, e_we, e_pcin); end
      model_clock();
      tick();
      n_tests++; if (order_valid !== m_ov || order_data !== m_od || order_pc !== m_opc) begin
        n_fail++; $display("FAIL rnd_order c%0d: got %0b %h %h want %0b %h %h", c, order_valid, order_data, order_pc, m_ov, m_od, m_opc); end
      n_tests++; if (fetch_timeout !== m_to) begin
        n_fail++; $display("FAIL rnd_to c%0d: got %0b want %0b", c, fetch_timeout, m_to); end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_ack_delay();
    test_redirect_pending();
    test_stall_hold();
    test_timeout();
    test_reset_midwait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
